// File: rtl/zelda_pkg.sv
// Shared state codes and constants for the per-frame game loop sequencer.
package zelda_pkg;

  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_INIT      = 4'd0;
  localparam state_t S_IDLE      = 4'd1;
  localparam state_t S_GEN_MOVE  = 4'd2;
  localparam state_t S_COLLIDE   = 4'd3;
  localparam state_t S_APPLY     = 4'd4;
  localparam state_t S_MOVE_EN   = 4'd5;
  localparam state_t S_DRAW_MAP  = 4'd6;
  localparam state_t S_DRAW_LINK = 4'd7;
  localparam state_t S_DRAW_EN   = 4'd8;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

endpackage

// File: rtl/phase_watchdog.sv
// Draw-phase timeout counter: cleared on load, expires after LIMIT cycles.
// Only built when WATCHDOG_EN is defined.
`ifdef WATCHDOG_EN
module phase_watchdog #(
  parameter int             W     = 24,
  parameter logic [W-1:0]   LIMIT = 24'd200000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  logic [W-1:0] count;

  // load marks the first cycle of a phase, so that cycle counts as one
  always_ff @(posedge clock) begin
    if (reset || !enable)
      count <= '0;
    else if (load)
      count <= W'(1);
    else
      count <= count + W'(1);
  end

  assign expire = enable && !load && (count == LIMIT - W'(1));

endmodule
`endif

// File: rtl/game_control.sv
// Per-frame game loop sequencer issuing one-hot phase strobes.
// WATCHDOG_EN adds a draw-phase timeout with a sticky wdog_err flag.
module game_control #(
  parameter int          COLLIDE_CYCLES = 2,
  parameter int          FRAME_W        = 16,
  parameter logic [23:0] WDOG_CYCLES    = 24'd200000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pause,
  input  logic               idle_done,
  input  logic               draw_map_done,
  input  logic               draw_link_done,
  input  logic               draw_enemies_done,
  output logic               init,
  output logic               idle,
  output logic               gen_move,
  output logic               check_collide,
  output logic               apply_act_link,
  output logic               move_enemies,
  output logic               draw_map,
  output logic               draw_link,
  output logic               draw_enemies,
  output logic [FRAME_W-1:0] frame_count,
  output logic [3:0]         state_dbg,
  output logic               wdog_err
);

  import zelda_pkg::*;

  localparam int CW = $clog2(COLLIDE_CYCLES + 1);

  state_t        state;
  state_t        state_nxt;
  logic          fresh;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] ccnt_nxt;
  logic          frame_inc;
  logic          expire;
  logic          in_draw;
  logic [8:0]    phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_INIT;
      fresh       <= ON;
      ccnt        <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      fresh <= (state_nxt != state);
      ccnt  <= ccnt_nxt;
      if (frame_inc)
        frame_count <= frame_count + FRAME_W'(1);
    end
  end

  // done levels are only trusted from the second cycle of a wait state
  always_comb begin
    state_nxt = state;
    ccnt_nxt  = ccnt;
    frame_inc = OFF;
    phase     = '0;
    case (state)
      S_INIT: begin
        phase[8]  = ON;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        phase[7] = ON;
        if (!fresh && idle_done && !pause)
          state_nxt = S_GEN_MOVE;
      end
      S_GEN_MOVE: begin
        phase[6]  = ON;
        state_nxt = S_COLLIDE;
      end
      S_COLLIDE: begin
        phase[5] = ON;
        if (ccnt == CW'(COLLIDE_CYCLES - 1)) begin
          ccnt_nxt  = '0;
          state_nxt = S_APPLY;
        end else begin
          ccnt_nxt = ccnt + CW'(1);
        end
      end
      S_APPLY: begin
        phase[4]  = ON;
        state_nxt = S_MOVE_EN;
      end
      S_MOVE_EN: begin
        phase[3]  = ON;
        state_nxt = S_DRAW_MAP;
      end
      S_DRAW_MAP: begin
        phase[2] = ON;
        if ((!fresh && draw_map_done) || expire)
          state_nxt = S_DRAW_LINK;
      end
      S_DRAW_LINK: begin
        phase[1] = ON;
        if ((!fresh && draw_link_done) || expire)
          state_nxt = S_DRAW_EN;
      end
      S_DRAW_EN: begin
        phase[0] = ON;
        if ((!fresh && draw_enemies_done) || expire) begin
          state_nxt = S_IDLE;
          frame_inc = ON;
        end
      end
      default: begin
        state_nxt = S_INIT;
        ccnt_nxt  = '0;
      end
    endcase
  end

  assign in_draw = (state == S_DRAW_MAP) ||
                   (state == S_DRAW_LINK) ||
                   (state == S_DRAW_EN);

`ifdef WATCHDOG_EN
  phase_watchdog #(
    .W     (24),
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .load   (fresh),
    .enable (in_draw),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset)
      wdog_err <= OFF;
    else if (expire)
      wdog_err <= ON;
  end
`else
  assign expire   = OFF;
  assign wdog_err = (WDOG_CYCLES == '0) && OFF && in_draw;
`endif

  assign {init, idle, gen_move, check_collide, apply_act_link,
          move_enemies, draw_map, draw_link, draw_enemies} =
         reset ? 9'b0 : phase;

  assign state_dbg = state;

endmodule
